time_keeper: RTL and testbench
==============================

# time_keeper

Real-time clock and time-setting controller for the alarm-clock design. It writes the 16-bit BCD `current` time word (HH:MM) that the display and alarm-check services read, advancing it once per second from a clock-cycle prescaler. It also lets the user edit hours and minutes with the five push buttons while service switch 1 is on.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 100000000: clock cycles per second.
- `HOLD_CYCLES`, default 50000000: hold time before auto-repeat starts (auto-repeat builds only).
- `REPEAT_CYCLES`, default 10000000: interval between auto-repeat steps (auto-repeat builds only).

Ports:
- `clk` input 1: system clock; single clock domain.
- `resetn` input 1: reset; synchronous, active-low.
- `set_en` input 1: time-setting enable, driven from the registered service-1 switch (SPDT1).
- `push_u`, `push_d`, `push_l`, `push_r`, `push_m` input 1 each: push buttons, already synchronised and debounced upstream.
- `current` output 16: BCD time as {H10,H1,M10,M1}.
- `seconds` output 8: BCD seconds as {S10,S1}.
- `mode` output 2: 00 = RUN, 01 = SET_HOUR, 10 = SET_MIN; 11 never occurs.
- `sec_tick` output 1: one-cycle pulse at each second boundary.

## Operation
- Button events:
  - Each button is registered into `push_q`; event = `push & ~push_q`.
  - `push_q` resets to all ones, so a button held through reset release produces no event.
- Event priority:
  - At most one event is acted on per cycle: m > u > d > l > r.
  - Lower-priority events in the same cycle are discarded.
- RUN state:
  - Prescaler counts 0..TICKS_PER_SEC-1 and wraps.
  - At the terminal count, `sec_tick`=1 and seconds increments: S1 9→0 carries into S10, and 59→00 carries into minutes.
  - Minutes 59→00 carries into hours; hours 23→00.
  - All digits stay valid BCD at all times.
- RUN→SET_HOUR: on an m event while `set_en`=1. The prescaler is cleared and then held at 0. `sec_tick` stays 0 in both SET states.
- SET_HOUR:
  - u: hour +1, wrapping 23→00.
  - d: hour −1, wrapping 00→23.
  - r: go to SET_MIN.
  - l: ignored.
- SET_MIN:
  - u: minute +1, wrapping 59→00.
  - d: minute −1, wrapping 00→59.
  - l: go to SET_HOUR.
  - r: ignored.
  - Minute edits never carry into hours.
- Leaving SET states:
  - An m event, or `set_en`=0, in either SET state commits: go to RUN, clear seconds and prescaler, keep the edited HH:MM.
  - `set_en`=0 takes precedence over any button event that cycle.
- Reset (`resetn`=0 at a clock edge, from any state, including mid-edit):
  - `current`=16'h0000, `seconds`=8'h00, `mode`=2'b00, `sec_tick`=0, prescaler=0, `push_q`=all ones, auto-repeat counter=0.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Button edge sampled at edge n: state and time change on edge n and are visible at cycle n+1.
- `sec_tick` is high for exactly one cycle, every TICKS_PER_SEC cycles in RUN. The incremented `seconds`/`current` are visible the cycle after `sec_tick`.
- After entering RUN from a commit, the first `sec_tick` occurs TICKS_PER_SEC cycles later.
- The 23:59:59→00:00:00 rollover completes in a single cycle; no intermediate value is visible.

## Configuration
- `TIMEKEEPER_AUTOREPEAT_EN` defined:
  - In SET states, holding u or d continuously for HOLD_CYCLES produces one extra step.
  - Further steps follow every REPEAT_CYCLES while the button stays held.
  - The counter clears on release, on state change, or when another button event occurs.
- Not defined: only rising edges generate steps; a held button produces exactly one step. HOLD_CYCLES and REPEAT_CYCLES are unused.

## Test plan
Bench uses TICKS_PER_SEC=4.
- Reset: `resetn`=0 for 2 cycles → `current`=16'h0000, `seconds`=8'h00, `mode`=00, `sec_tick`=0. Release → first `sec_tick` 4 cycles later, then `seconds`=8'h01.
- Edit and roll over:
  - `set_en`=1, m → `mode`=01; d → `current`=16'h2300.
  - r → `mode`=10; d → 16'h2359.
  - m → `mode`=00, `seconds`=00.
  - After 60 ticks (240 cycles) → `current`=16'h0000, `seconds`=8'h00.
- Wraps:
  - SET_HOUR at 23, u → hour 00.
  - SET_MIN at 59, u → 16'hxx00 with the hour unchanged.
  - SET_MIN at 00, d → minute 59.
- Held and simultaneous buttons (macro off):
  - u held 20 cycles in SET_HOUR → exactly one increment.
  - m and u rising in the same cycle in SET_HOUR → `mode`=00, hour unchanged.
  - `set_en` dropped in SET_MIN → `mode`=00 next cycle.
- Reset mid-edit: `resetn`=0 in SET_MIN at 16'h1234 → next cycle `current`=0000, `mode`=00. A u held across reset release → no increment.
- Auto-repeat (macro on, HOLD_CYCLES=8, REPEAT_CYCLES=4): u held 20 cycles in SET_HOUR from 00 → hour 04 (1 edge + 1 at hold + 2 repeats).

Source files
------------

// File: rtl/time_keeper.sv
// time_keeper
//   Real-time clock and time-setting controller. Keeps a BCD HH:MM:SS time
//   that advances once per second in RUN. While set_en is on, the push
//   buttons let the user edit hours and minutes.
//
//   Optional build macro: TIMEKEEPER_AUTOREPEAT_EN
//     When defined, holding u or d in a SET state for HOLD_CYCLES gives one
//     extra step, then one more step every REPEAT_CYCLES while still held.
//     When undefined, each rising edge gives exactly one step.
//
// Ports
//   clk       system clock
//   resetn    synchronous active-low reset
//   set_en    time-setting enable (service switch 1)
//   push_u/d/l/r/m  debounced push buttons (level)
//   current   BCD {H10,H1,M10,M1}
//   seconds   BCD {S10,S1}
//   mode      00 RUN, 01 SET_HOUR, 10 SET_MIN
//   sec_tick  one-cycle pulse per second in RUN
module time_keeper #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        set_en,
  input  logic        push_u,
  input  logic        push_d,
  input  logic        push_l,
  input  logic        push_r,
  input  logic        push_m,
  output logic [15:0] current,
  output logic [7:0]  seconds,
  output logic [1:0]  mode,
  output logic        sec_tick
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [7:0]    hour_n, min_n, sec_n;
  logic          tick_n;
  logic [4:0]    push_vec, push_q, ev;
  logic          ev_m, ev_u, ev_d, ev_l, ev_r, any_ev;
  logic          rep_up_fire, rep_dn_fire;
  logic          step_up, step_dn;

  // BCD digit helpers; every result stays valid BCD.
  function automatic logic [7:0] hour_inc(input logic [7:0] h);
    if (h == 8'h23)      return 8'h00;
    if (h[3:0] == 4'd9)  return {h[7:4] + 4'd1, 4'd0};
    return h + 8'd1;
  endfunction

  function automatic logic [7:0] hour_dec(input logic [7:0] h);
    if (h == 8'h00)      return 8'h23;
    if (h[3:0] == 4'd0)  return {h[7:4] - 4'd1, 4'd9};
    return h - 8'd1;
  endfunction

  function automatic logic [7:0] sixty_inc(input logic [7:0] v);
    if (v == 8'h59)      return 8'h00;
    if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
    return v + 8'd1;
  endfunction

  function automatic logic [7:0] sixty_dec(input logic [7:0] v);
    if (v == 8'h00)      return 8'h59;
    if (v[3:0] == 4'd0)  return {v[7:4] - 4'd1, 4'd9};
    return v - 8'd1;
  endfunction

  // Button edges with fixed priority m > u > d > l > r.
  assign push_vec = {push_m, push_u, push_d, push_l, push_r};
  assign ev       = push_vec & ~push_q;
  assign any_ev   = |ev;
  assign ev_m     = ev[4];
  assign ev_u     = ev[3] & ~ev[4];
  assign ev_d     = ev[2] & ~|ev[4:3];
  assign ev_l     = ev[1] & ~|ev[4:2];
  assign ev_r     = ev[0] & ~|ev[4:1];

`ifdef TIMEKEEPER_AUTOREPEAT_EN
  localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW   = $clog2(RMAX) + 1;

  logic [CW-1:0] rep_cnt;
  logic          rep_phase;
  logic          rep_keep, rep_fire;

  // Counting continues only while a u/d is held in a SET state with no
  // new button edge and no exit; anything else restarts the hold delay.
  assign rep_keep = (state != RUN) && set_en && !any_ev && (push_u || push_d);
  assign rep_fire = rep_keep && (rep_phase ? (rep_cnt == CW'(REPEAT_CYCLES - 1))
                                           : (rep_cnt == CW'(HOLD_CYCLES - 1)));
  assign rep_up_fire = rep_fire && push_u;
  assign rep_dn_fire = rep_fire && !push_u;

  always_ff @(posedge clk) begin
    if (!resetn || !rep_keep) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b1;
    end else begin
      rep_cnt   <= rep_cnt + CW'(1);
    end
  end
`else
  localparam int unused_cfg = HOLD_CYCLES + REPEAT_CYCLES;
  assign rep_up_fire = 1'b0;
  assign rep_dn_fire = 1'b0;
`endif

  assign step_up = ev_u | rep_up_fire;
  assign step_dn = ev_d | rep_dn_fire;

  always_comb begin
    state_n = state;
    presc_n = presc;
    tick_n  = 1'b0;
    hour_n  = current[15:8];
    min_n   = current[7:0];
    sec_n   = seconds;
    case (state)
      RUN: begin
        if (presc == PRESC_LAST) begin
          presc_n = '0;
          tick_n  = 1'b1;
        end else begin
          presc_n = presc + PW'(1);
        end
        // The registered tick one cycle ago applies the increment now, so
        // the new time is visible the cycle after sec_tick.
        if (sec_tick) begin
          sec_n = sixty_inc(seconds);
          if (seconds == 8'h59) begin
            min_n = sixty_inc(current[7:0]);
            if (current[7:0] == 8'h59) hour_n = hour_inc(current[15:8]);
          end
        end
        if (ev_m && set_en) begin
          state_n = SET_HOUR;
          presc_n = '0;
          tick_n  = 1'b0;
        end
      end
      SET_HOUR: begin
        presc_n = '0;
        if (!set_en || ev_m) begin
          state_n = RUN;
          sec_n   = 8'h00;
        end else if (step_up) begin
          hour_n  = hour_inc(current[15:8]);
        end else if (step_dn) begin
          hour_n  = hour_dec(current[15:8]);
        end else if (ev_r) begin
          state_n = SET_MIN;
        end
      end
      SET_MIN: begin
        presc_n = '0;
        if (!set_en || ev_m) begin
          state_n = RUN;
          sec_n   = 8'h00;
        end else if (step_up) begin
          min_n   = sixty_inc(current[7:0]);
        end else if (step_dn) begin
          min_n   = sixty_dec(current[7:0]);
        end else if (ev_l) begin
          state_n = SET_HOUR;
        end
      end
      default: begin
        state_n = RUN;
        presc_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= RUN;
      presc    <= '0;
      current  <= 16'h0000;
      seconds  <= 8'h00;
      sec_tick <= 1'b0;
      push_q   <= '1;
    end else begin
      state    <= state_n;
      presc    <= presc_n;
      current  <= {hour_n, min_n};
      seconds  <= sec_n;
      sec_tick <= tick_n;
      push_q   <= push_vec;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_time_keeper.sv
module tb_time_keeper;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        set_en = 1'b0;
  logic [4:0]  pb = 5'b0;       // {m,u,d,l,r}
  logic [15:0] current;
  logic [7:0]  seconds;
  logic [1:0]  mode;
  logic        sec_tick;

  int checks = 0;
  int failures = 0;

  localparam logic [4:0] BM = 5'b10000, BU = 5'b01000, BD = 5'b00100,
                         BL = 5'b00010, BR = 5'b00001;

  time_keeper #(.TICKS_PER_SEC(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut (
    .clk(clk), .resetn(resetn), .set_en(set_en),
    .push_u(pb[3]), .push_d(pb[2]), .push_l(pb[1]), .push_r(pb[0]), .push_m(pb[4]),
    .current(current), .seconds(seconds), .mode(mode), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One idle edge so the button is seen low, then one edge with it high.
  task automatic press(input logic [4:0] b);
    pb = 5'b0;
    cyc();
    pb = b;
    cyc();
    pb = 5'b0;
  endtask

  typedef struct {
    logic [4:0]  btn;
    logic [1:0]  mode;
    logic [15:0] cur;
    logic        chk_sec;
    logic [7:0]  sec;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int n;
    int ticks;
    int last;
    int bad_gap;
    logic seen;

    tbl[0]  = '{BM, 2'b01, 16'h0000, 1'b0, 8'h00};
    tbl[1]  = '{BD, 2'b01, 16'h2300, 1'b0, 8'h00};
    tbl[2]  = '{BU, 2'b01, 16'h0000, 1'b0, 8'h00};
    tbl[3]  = '{BD, 2'b01, 16'h2300, 1'b0, 8'h00};
    tbl[4]  = '{BL, 2'b01, 16'h2300, 1'b0, 8'h00};
    tbl[5]  = '{BR, 2'b10, 16'h2300, 1'b0, 8'h00};
    tbl[6]  = '{BD, 2'b10, 16'h2359, 1'b0, 8'h00};
    tbl[7]  = '{BU, 2'b10, 16'h2300, 1'b0, 8'h00};
    tbl[8]  = '{BD, 2'b10, 16'h2359, 1'b0, 8'h00};
    tbl[9]  = '{BR, 2'b10, 16'h2359, 1'b0, 8'h00};
    tbl[10] = '{BL, 2'b01, 16'h2359, 1'b0, 8'h00};
    tbl[11] = '{BR, 2'b10, 16'h2359, 1'b0, 8'h00};
    tbl[12] = '{BM, 2'b00, 16'h2359, 1'b1, 8'h00};

    // Reset
    resetn = 1'b0;
    cyc(); cyc();
    chk("rst_current", current, 16'h0000);
    chk("rst_seconds", {8'h0, seconds}, 16'h0000);
    chk("rst_mode", {14'h0, mode}, 16'h0000);
    chk("rst_tick", {15'h0, sec_tick}, 16'h0000);
    resetn = 1'b1;
    n = 0; seen = 1'b0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      cyc();
      if (sec_tick) begin seen = 1'b1; n = i; end
    end
    chk("first_tick_latency", 16'(n), 16'd4);
    cyc();
    chk("seconds_after_tick", {8'h0, seconds}, 16'h0001);
    chk("tick_one_cycle", {15'h0, sec_tick}, 16'h0000);

    // Edit table
    set_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      press(tbl[i].btn);
      chk($sformatf("vec%0d_mode", i), {14'h0, mode}, {14'h0, tbl[i].mode});
      chk($sformatf("vec%0d_current", i), current, tbl[i].cur);
      if (tbl[i].chk_sec) chk($sformatf("vec%0d_seconds", i), {8'h0, seconds}, {8'h0, tbl[i].sec});
    end

    // First tick after commit, then 60 ticks to midnight rollover
    ticks = 0; last = 0; bad_gap = 0; n = 0;
    for (int i = 1; i <= 300 && ticks < 60; i++) begin
      cyc();
      if (sec_tick) begin
        ticks++;
        if (ticks == 1) n = i;
        else if (i - last != 4) bad_gap++;
        last = i;
      end
    end
    chk("commit_first_tick", 16'(n), 16'd4);
    chk("tick_count", 16'(ticks), 16'd60);
    chk("tick_spacing_errors", 16'(bad_gap), 16'd0);
    chk("pre_roll_current", current, 16'h2359);
    chk("pre_roll_seconds", {8'h0, seconds}, 16'h0059);
    cyc();
    chk("roll_current", current, 16'h0000);
    chk("roll_seconds", {8'h0, seconds}, 16'h0000);

    // Held u in SET_HOUR from 00
    press(BM);
    chk("enter_set_mode", {14'h0, mode}, 16'h0001);
    cyc();
    pb = BU;
    for (int i = 0; i < 20; i++) cyc();
    pb = 5'b0;
    cyc();
`ifdef TIMEKEEPER_AUTOREPEAT_EN
    chk("held_u_autorepeat", current, 16'h0400);
`else
    chk("held_u_single_step", current, 16'h0100);
`endif

    // m and u together: commit wins, hour unchanged
    press(BM | BU);
    chk("m_u_same_mode", {14'h0, mode}, 16'h0000);
`ifdef TIMEKEEPER_AUTOREPEAT_EN
    chk("m_u_same_current", current, 16'h0400);
`else
    chk("m_u_same_current", current, 16'h0100);
`endif

    // Reach 12:34 in SET_MIN, then set_en drop beats a u event
    press(BM);
    while (current[15:8] != 8'h12 && n < 40) begin press(BU); n++; end
    press(BR);
    for (int i = 0; i < 34; i++) press(BU);
    chk("edit_to_1234", current, 16'h1234);
    chk("in_set_min", {14'h0, mode}, 16'h0002);
    pb = 5'b0; cyc();
    set_en = 1'b0;
    pb = BU;
    cyc();
    pb = 5'b0;
    chk("set_en_drop_mode", {14'h0, mode}, 16'h0000);
    chk("set_en_drop_current", current, 16'h1234);
    chk("set_en_drop_seconds", {8'h0, seconds}, 16'h0000);

    // Reset mid-edit with m and u held through release
    set_en = 1'b1;
    press(BM);
    press(BR);
    chk("back_in_set_min", {14'h0, mode}, 16'h0002);
    resetn = 1'b0;
    pb = BM | BU;
    cyc();
    chk("mid_rst_current", current, 16'h0000);
    chk("mid_rst_mode", {14'h0, mode}, 16'h0000);
    resetn = 1'b1;
    cyc(); cyc(); cyc();
    chk("held_thru_rst_mode", {14'h0, mode}, 16'h0000);
    chk("held_thru_rst_current", current, 16'h0000);
    pb = 5'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
